// File: rtl/mem_io_pkg.sv
// mem_io_pkg
// Shared constants and the address decoder for the memory-side responder.
//   IO_RXTX_ADDR : UART byte port (read pops RX, write pushes TX)
//   IO_CNT_ADDR  : cycle counter byte 0 / program-stop register
//   IO_MASK      : value of addr[17:16] that selects the I/O window
//   target_e     : decode result for one bus access
package mem_io_pkg;

    localparam logic [17:0] IO_RXTX_ADDR = 18'h30000;
    localparam logic [17:0] IO_CNT_ADDR  = 18'h30004;
    localparam logic [1:0]  IO_MASK      = 2'b11;

    typedef enum logic [1:0] {
        TGT_RAM  = 2'd0,
        TGT_RXTX = 2'd1,
        TGT_CNT  = 2'd2,
        TGT_NONE = 2'd3
    } target_e;

    // Classify an 18-bit bus address. The counter occupies four
    // consecutive bytes, so only the upper 16 bits are compared.
    function automatic target_e decode(input logic [17:0] a);
        if (a[17:16] != IO_MASK) begin
            return TGT_RAM;
        end else if (a == IO_RXTX_ADDR) begin
            return TGT_RXTX;
        end else if (a[17:2] == IO_CNT_ADDR[17:2]) begin
            return TGT_CNT;
        end else begin
            return TGT_NONE;
        end
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
// Single-clock FIFO with an occupancy counter and wrap-around pointers.
// The head entry is presented combinationally on dout.
//   clk, rst : clock, synchronous active-high reset (flushes the FIFO)
//   push/din : write request and data; ignored when full unless a pop
//              happens in the same cycle
//   pop      : remove head; ignored when empty
//   dout     : head entry (undefined contents when empty)
//   empty, full, free : status; free = number of unused entries
module sync_fifo #(
    parameter int W  = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   free
);

    localparam int          DEPTH   = 2 ** AW;
    localparam logic [AW:0] DEPTH_C = {1'b1, {AW{1'b0}}};

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty = (count == '0);
    assign full  = (count == DEPTH_C);
    assign free  = DEPTH_C - count;
    assign dout  = mem[rd_ptr];

    // A pop on a full FIFO frees the slot the simultaneous push lands in.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_io_responder.sv
// mem_io_responder
// Memory-side responder for the CPU byte bus: 128 KB RAM plus an I/O
// window (UART RX/TX FIFOs, cycle counter, program stop).
//   clk_in, rst_in        : clock, synchronous active-high reset
//   mem_a/mem_dout/mem_wr : CPU bus, sampled every edge (no strobe)
//   mem_din               : read data, valid one edge after the address
//   rdy_out               : low pauses the CPU when TX space runs short
//   rx_data/rx_valid      : UART input bytes into the RX FIFO
//   rx_overflow           : sticky, an RX byte was dropped
//   tx_data/tx_valid/tx_ready : UART output; a byte moves on an edge where
//                           tx_valid && tx_ready. tx_valid stays high and
//                           tx_data stable until that transfer happens.
//   prog_stop             : sticky, program wrote the stop register
module mem_io_responder
    import mem_io_pkg::*;
#(
    parameter int RAM_AW  = 17,
    parameter int FIFO_AW = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        rdy_out,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_overflow,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        prog_stop
);

    logic [17:0]       bus_addr;
    target_e           tgt;
    logic              unused_addr_bits;

    assign bus_addr         = mem_a[17:0];
    assign tgt              = decode(bus_addr);
    assign unused_addr_bits = ^mem_a[31:18];

    // ---------------- RAM (synchronous read, old data on collision)
    logic [7:0]        ram [2 ** RAM_AW];
    logic [7:0]        ram_q;
    logic [RAM_AW-1:0] ram_addr;

    assign ram_addr = mem_a[RAM_AW-1:0];

    always_ff @(posedge clk_in) begin
        if (tgt == TGT_RAM && mem_wr && !rst_in) begin
            ram[ram_addr] <= mem_dout;
        end
        ram_q <= ram[ram_addr];
    end

    // ---------------- RX FIFO
    logic [7:0]       rx_head;
    logic             rx_empty;
    logic             rx_full;
    logic [FIFO_AW:0] rx_free_unused;
    logic             rx_pop;

    assign rx_pop = (tgt == TGT_RXTX) && !mem_wr && !rx_empty;

    sync_fifo #(.W(8), .AW(FIFO_AW)) u_rx_fifo (
        .clk   (clk_in),
        .rst   (rst_in),
        .push  (rx_valid),
        .din   (rx_data),
        .pop   (rx_pop),
        .dout  (rx_head),
        .empty (rx_empty),
        .full  (rx_full),
        .free  (rx_free_unused)
    );

    // ---------------- TX FIFO
    logic [7:0]       tx_head;
    logic             tx_empty;
    logic             tx_full_unused;
    logic [FIFO_AW:0] tx_free;
    logic             stop_wr;
    logic             tx_push;
    logic [7:0]       tx_din;

    // The stop write pushes a 0x00 terminator; plain zero writes to the
    // port are treated as no-ops.
    assign stop_wr = mem_wr && (bus_addr == IO_CNT_ADDR);
    assign tx_push = stop_wr || (mem_wr && tgt == TGT_RXTX && mem_dout != 8'h00);
    assign tx_din  = (tgt == TGT_RXTX) ? mem_dout : 8'h00;

    sync_fifo #(.W(8), .AW(FIFO_AW)) u_tx_fifo (
        .clk   (clk_in),
        .rst   (rst_in),
        .push  (tx_push),
        .din   (tx_din),
        .pop   (tx_valid && tx_ready),
        .dout  (tx_head),
        .empty (tx_empty),
        .full  (tx_full_unused),
        .free  (tx_free)
    );

    assign tx_valid = !tx_empty;
    assign tx_data  = tx_empty ? 8'h00 : tx_head;

    // ---------------- counter, I/O read data, status
    logic [31:0] cycle_cnt;
    logic [31:8] cnt_snap;   // byte 0 is always served live, never from the snapshot
    logic [7:0]  io_rdata;
    logic [7:0]  io_q;
    logic        sel_ram_q;

    always_comb begin
        io_rdata = 8'h00;
        if (!mem_wr) begin
            case (tgt)
                TGT_RXTX: io_rdata = rx_empty ? 8'h00 : rx_head;
                TGT_CNT: begin
                    case (bus_addr[1:0])
                        2'd0:    io_rdata = cycle_cnt[7:0];
                        2'd1:    io_rdata = cnt_snap[15:8];
                        2'd2:    io_rdata = cnt_snap[23:16];
                        default: io_rdata = cnt_snap[31:24];
                    endcase
                end
                default: io_rdata = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cycle_cnt   <= '0;
            cnt_snap    <= '0;
            io_q        <= 8'h00;
            sel_ram_q   <= 1'b0;
            rdy_out     <= 1'b1;
            prog_stop   <= 1'b0;
            rx_overflow <= 1'b0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            io_q      <= io_rdata;
            sel_ram_q <= (tgt == TGT_RAM);
            // Margin of 2 covers the write already in flight when the CPU
            // sees rdy_out fall.
            rdy_out   <= (tx_free > (FIFO_AW + 1)'(2));
            if (!mem_wr && bus_addr == IO_CNT_ADDR) begin
                cnt_snap <= cycle_cnt[31:8];
            end
            if (stop_wr) begin
                prog_stop <= 1'b1;
            end
            if (rx_valid && rx_full && !rx_pop) begin
                rx_overflow <= 1'b1;
            end
        end
    end

    assign mem_din = sel_ram_q ? ram_q : io_q;

endmodule

// File: tb/tb_mem_io_responder.sv
module tb_mem_io_responder;

    // ---------------- clock / reset
    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    always #5 clk_in = ~clk_in;

    logic [31:0] mem_a = '0;
    logic [7:0]  mem_dout = '0;
    logic        mem_wr = 1'b0;
    logic [7:0]  mem_din;
    logic        rdy_out;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_overflow;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        prog_stop;

    mem_io_responder dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .mem_a       (mem_a),
        .mem_dout    (mem_dout),
        .mem_wr      (mem_wr),
        .mem_din     (mem_din),
        .rdy_out     (rdy_out),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_overflow (rx_overflow),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .prog_stop   (prog_stop)
    );

    // ---------------- counters and check helper
    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    // ---------------- behavioural model (queues + plain arithmetic)
    logic [7:0]  m_ram [int];
    logic [7:0]  m_rxq [$];
    logic [7:0]  m_txq [$];
    logic [31:0] m_cnt = '0;
    logic [31:0] m_snap = '0;
    logic        m_stop = 1'b0;
    logic        m_ovf = 1'b0;
    logic [7:0]  m_din = '0;
    logic        m_din_known = 1'b1;
    logic        m_rdy = 1'b1;
    bit          started = 1'b0;
    logic [17:0] ma;
    int          ra;

    always @(posedge clk_in) begin
        started = 1'b1;
        if (rst_in) begin
            m_rxq.delete();
            m_txq.delete();
            m_cnt = '0;
            m_snap = '0;
            m_stop = 1'b0;
            m_ovf = 1'b0;
            m_din = 8'h00;
            m_din_known = 1'b1;
            m_rdy = 1'b1;
        end else begin
            ma = mem_a[17:0];
            m_rdy = (16 - m_txq.size()) > 2;
            if (m_txq.size() > 0 && tx_ready) void'(m_txq.pop_front());
            m_din = 8'h00;
            m_din_known = !mem_wr;
            if (ma[17:16] != 2'b11) begin
                ra = int'(mem_a[16:0]);
                if (mem_wr) m_ram[ra] = mem_dout;
                else if (m_ram.exists(ra)) m_din = m_ram[ra];
                else m_din_known = 1'b0;
            end else if (ma == 18'h30000) begin
                if (mem_wr) begin
                    if (mem_dout != 8'h00 && m_txq.size() < 16) m_txq.push_back(mem_dout);
                end else if (m_rxq.size() > 0) begin
                    m_din = m_rxq.pop_front();
                end
            end else if (ma >= 18'h30004 && ma <= 18'h30007) begin
                if (mem_wr) begin
                    if (ma == 18'h30004) begin
                        m_stop = 1'b1;
                        if (m_txq.size() < 16) m_txq.push_back(8'h00);
                    end
                end else begin
                    case (ma[1:0])
                        2'd0: begin m_din = m_cnt[7:0]; m_snap = m_cnt; end
                        2'd1: m_din = m_snap[15:8];
                        2'd2: m_din = m_snap[23:16];
                        default: m_din = m_snap[31:24];
                    endcase
                end
            end
            if (rx_valid) begin
                if (m_rxq.size() < 16) m_rxq.push_back(rx_data);
                else m_ovf = 1'b1;
            end
            m_cnt = m_cnt + 32'd1;
        end
    end

    // ---------------- scoreboard: bytes the UART must receive, in order
    logic [7:0] exp_q [$];

    // ---------------- single compare process, every cycle
    always @(negedge clk_in) begin
        if (started) begin
            if (m_din_known) check("mem_din", {24'h0, mem_din}, {24'h0, m_din});
            check("rdy_out", {31'h0, rdy_out}, {31'h0, m_rdy});
            check("tx_valid", {31'h0, tx_valid}, {31'h0, m_txq.size() > 0});
            check("tx_data", {24'h0, tx_data}, {24'h0, (m_txq.size() > 0) ? m_txq[0] : 8'h00});
            check("prog_stop", {31'h0, prog_stop}, {31'h0, m_stop});
            check("rx_overflow", {31'h0, rx_overflow}, {31'h0, m_ovf});
            if (tx_valid && tx_ready && !rst_in) begin
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL uart_unexpected actual=%h required=none at %0t", tx_data, $time);
                end else begin
                    check("uart_byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
                end
            end
        end
    end

    // ---------------- driver tasks
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [7:0] d);
        mem_a = a; mem_dout = d; mem_wr = 1'b1;
        tick();
        mem_a = '0; mem_dout = '0; mem_wr = 1'b0;
    endtask

    task automatic bus_rd(input logic [31:0] a);
        mem_a = a; mem_wr = 1'b0;
        tick();
        mem_a = '0;
    endtask

    task automatic rx_push(input logic [7:0] d);
        rx_data = d; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0; rx_data = '0;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        tick();
        tick();
        rst_in = 1'b0;
    endtask

    // ---------------- directed stimulus with literal expectations
    initial begin
        rst_in = 1'b1;
        tick();
        tick();
        check("reset_mem_din", {24'h0, mem_din}, 32'h00);
        check("reset_rdy", {31'h0, rdy_out}, 32'h1);
        check("reset_tx_valid", {31'h0, tx_valid}, 32'h0);
        rst_in = 1'b0;

        // RAM
        bus_wr(32'h0_0010, 8'hA5);
        bus_rd(32'h0_0010);
        check("ram_0010", {24'h0, mem_din}, 32'hA5);
        bus_wr(32'h1_FFFF, 8'h3C);
        bus_rd(32'h1_FFFF);
        check("ram_1ffff", {24'h0, mem_din}, 32'h3C);

        // RX basic
        rx_push(8'h41);
        rx_push(8'h42);
        bus_rd(32'h3_0000); check("rx_first", {24'h0, mem_din}, 32'h41);
        bus_rd(32'h3_0000); check("rx_second", {24'h0, mem_din}, 32'h42);
        bus_rd(32'h3_0000); check("rx_empty", {24'h0, mem_din}, 32'h00);

        // RX overflow: 17 pushes, first 16 survive
        for (int i = 0; i < 17; i++) rx_push(8'h60 + 8'(i));
        check("rx_overflow_set", {31'h0, rx_overflow}, 32'h1);
        for (int i = 0; i < 16; i++) begin
            bus_rd(32'h3_0000);
            check("rx_ovf_data", {24'h0, mem_din}, 32'h60 + i);
        end
        bus_rd(32'h3_0000); check("rx_ovf_drained", {24'h0, mem_din}, 32'h00);

        // TX with zero suppression
        tx_ready = 1'b1;
        exp_q.push_back(8'h48);
        exp_q.push_back(8'h49);
        bus_wr(32'h3_0000, 8'h48);
        bus_wr(32'h3_0000, 8'h00);
        bus_wr(32'h3_0000, 8'h49);
        repeat (5) tick();
        check("tx_zero_skip_drained", exp_q.size(), 32'd0);

        // Backpressure
        tx_ready = 1'b0;
        for (int i = 1; i <= 13; i++) bus_wr(32'h3_0000, 8'(i));
        check("rdy_13", {31'h0, rdy_out}, 32'h1);
        bus_wr(32'h3_0000, 8'd14);
        check("rdy_14_lag", {31'h0, rdy_out}, 32'h1);
        tick();
        check("rdy_fall", {31'h0, rdy_out}, 32'h0);
        bus_wr(32'h3_0000, 8'd15);
        bus_wr(32'h3_0000, 8'd16);
        bus_wr(32'h3_0000, 8'h77);   // FIFO full: dropped
        for (int i = 1; i <= 16; i++) exp_q.push_back(8'(i));
        tx_ready = 1'b1;
        repeat (20) tick();
        check("tx_no_loss", exp_q.size(), 32'd0);
        check("rdy_recovered", {31'h0, rdy_out}, 32'h1);

        // Counter, no carry
        do_reset();
        repeat (100) tick();
        bus_rd(32'h3_0004); check("cnt100_b0", {24'h0, mem_din}, 32'h64);
        bus_rd(32'h3_0005); check("cnt100_b1", {24'h0, mem_din}, 32'h00);
        bus_rd(32'h3_0006); check("cnt100_b2", {24'h0, mem_din}, 32'h00);
        bus_rd(32'h3_0007); check("cnt100_b3", {24'h0, mem_din}, 32'h00);

        // Counter, byte-0 about to carry
        do_reset();
        repeat (255) tick();
        bus_rd(32'h3_0004); check("cnt255_b0", {24'h0, mem_din}, 32'hFF);
        bus_rd(32'h3_0005); check("cnt255_b1", {24'h0, mem_din}, 32'h00);
        bus_rd(32'h3_0006); check("cnt255_b2", {24'h0, mem_din}, 32'h00);
        bus_rd(32'h3_0007); check("cnt255_b3", {24'h0, mem_din}, 32'h00);

        // Unmapped I/O
        bus_rd(32'h3_0008); check("io_unmapped", {24'h0, mem_din}, 32'h00);

        // Stop
        tx_ready = 1'b1;
        exp_q.push_back(8'h00);
        bus_wr(32'h3_0004, 8'h55);
        check("stop_set", {31'h0, prog_stop}, 32'h1);
        repeat (5) tick();
        check("stop_sticky", {31'h0, prog_stop}, 32'h1);
        check("stop_zero_sent", exp_q.size(), 32'd0);

        // Reset mid-traffic
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) rx_push(8'h70 + 8'(i));
        for (int i = 0; i < 8; i++) bus_wr(32'h3_0000, 8'h80 + 8'(i));
        rst_in = 1'b1;
        tick();
        check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("rst_rdy", {31'h0, rdy_out}, 32'h1);
        check("rst_stop", {31'h0, prog_stop}, 32'h0);
        rst_in = 1'b0;
        bus_rd(32'h3_0000); check("rst_rx_flushed", {24'h0, mem_din}, 32'h00);
        bus_rd(32'h3_0004); check("rst_cnt_cleared", {24'h0, mem_din}, 32'h01);
        repeat (3) tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mem_io_responder.md
# mem_io_responder

Memory-side responder for the CPU's byte-wide memory bus (`mem_a`, `mem_dout`, `mem_din`, `mem_wr`). It decodes each bus access to one of two targets: a 128 KB byte RAM, or the I/O window at `mem_a[17:16]==2'b11`. It answers reads with one cycle of latency, buffers UART input and output bytes in FIFOs, keeps the cycle counter, and drives the CPU's `rdy_in` low to pause it when the output path backs up.

## Interface
Parameters:
- `RAM_AW`, default 17: RAM byte-address width (128 KB).
- `FIFO_AW`, default 4: log2 of the RX and TX FIFO depth (16 entries each).

Ports:
- `clk_in` input 1: system clock. One clock domain.
- `rst_in` input 1: reset, synchronous and active-high.
- `mem_a` input 32: CPU address. Only bits [17:0] are decoded.
- `mem_dout` input 8: CPU write data.
- `mem_wr` input 1: 1 = write, 0 = read.
- `mem_din` output 8: read data to the CPU.
- `rdy_out` output 1: drives the CPU's `rdy_in`. Low pauses the CPU.
- `rx_data` input 8: incoming UART byte.
- `rx_valid` input 1: push `rx_data` into the RX FIFO.
- `rx_overflow` output 1: sticky; a byte was dropped because the RX FIFO was full.
- `tx_data` output 8: head of the TX FIFO.
- `tx_valid` output 1: TX FIFO is not empty.
- `tx_ready` input 1: the UART accepts the head byte on `tx_valid && tx_ready`.
- `prog_stop` output 1: sticky; the program has written 0x30004.

## Operation
- The bus is sampled every `clk_in` edge. There is no request strobe: every cycle is an access, and a read with no side effects is harmless.
- Decode rules:
  - `mem_a[17:16] != 2'b11`: RAM at `mem_a[RAM_AW-1:0]`.
  - 0x30000: RX/TX port.
  - 0x30004–0x30007: counter / stop.
  - Any other I/O address: reads return 0x00, writes are ignored.
- RAM write: the byte is stored at the edge. RAM read: `mem_din` shows the byte at the next edge. Read-during-write to the same address returns the old byte.
- Read 0x30000: if the RX FIFO is non-empty, return its head and pop it; if empty, return 0x00 and do not pop.
- Write 0x30000: push `mem_dout` into the TX FIFO. A value of 0x00 is ignored (no push).
- Counter:
  - 32-bit `cycle_cnt` resets to 0, increments every cycle, and wraps at 2^32.
  - A read of 0x30004 latches `cnt_snap <= cycle_cnt` and returns byte 0 of the current `cycle_cnt`.
  - Reads of 0x30005/6/7 return byte 1/2/3 of `cnt_snap`, so a 4-byte read sequence is coherent.
- Write 0x30004: `prog_stop <= 1` and push 0x00 into the TX FIFO, bypassing the zero-ignore rule.
- RX FIFO:
  - Push on `rx_valid`.
  - A push while full is dropped and sets `rx_overflow`.
  - A push and a pop in the same cycle on a non-empty FIFO both take effect, and the count is unchanged.
  - A push to an empty FIFO is not visible to a bus read in the same cycle.
- TX FIFO: push from the bus and pop on `tx_valid && tx_ready` may occur in the same cycle.
- Backpressure:
  - `rdy_out` is registered: `rdy_out <= (tx_free > 2)`.
  - Because of that margin, a write already in flight when `rdy_out` falls always finds space.
  - A push into a full TX FIFO is dropped anyway, as a defensive rule.
- Bus activity during `rdy_out` low is still serviced. While paused, the CPU holds reset-like idle values (reads of address 0).

## Timing
- Reset values:
  - `mem_din` = 0x00, `rdy_out` = 1, `tx_valid` = 0, `tx_data` = 0x00.
  - `prog_stop` = 0, `rx_overflow` = 0, `cycle_cnt` = 0, `cnt_snap` = 0.
  - Both FIFOs empty.
- RAM contents are not reset.
- Read latency is exactly 1 cycle: address at edge N, data in `mem_din` after edge N+1. This matches the CPU's 2-cycle read.
- Write latency is 0 wait cycles; the write takes effect at the sampling edge.
- `rdy_out` reacts 1 cycle after the change in TX occupancy.
- Reset asserted mid-operation: both FIFOs are flushed and the counter is cleared at the next edge. Reset overrides any simultaneous push, pop or write.

## Structure
- Package `mem_io_pkg` holds:
  - constants `IO_RXTX_ADDR=18'h30000` and `IO_CNT_ADDR=18'h30004`;
  - the I/O decode mask `2'b11`;
  - an enum for the decode target (RAM, RXTX, CNT, NONE).
- Sub-module `sync_fifo` (width 8, depth `2**FIFO_AW`) is instantiated twice, for RX and TX.
  - Ports: `clk`, `rst`, `push`, `din`, `pop`, `dout`, `empty`, `full`, `free`.
  - Uses a count register plus wrap-around read and write pointers.
- RAM is inferred as a synchronous-read byte array.

## Test plan
- RAM: write 0xA5 to 0x00010, then read it back. `mem_din` = 0xA5 exactly one cycle after the read address. Reading 0x1FFFF after writing 0x3C there returns 0x3C.
- RX path:
  - Push 0x41 and 0x42 via `rx_valid`, then read 0x30000 three times: 0x41, 0x42, then 0x00.
  - Push 17 bytes with no reads: `rx_overflow` = 1 and only the first 16 are returned.
- TX path:
  - Write 0x48, then 0x00, then 0x49 to 0x30000 with `tx_ready` = 1: the UART sees 0x48 then 0x49 only.
  - With `tx_ready` held 0, `rdy_out` falls once free ≤ 2, and no byte is lost.
- Counter: after reset, hold reads of address 0 for 100 cycles, then read 0x30004–0x30007 on consecutive cycles. The assembled value equals the `cycle_cnt` at the 0x30004 read, and bytes 1–3 are unaffected by a byte-0 carry.
- Stop: write 0x30004: `prog_stop` = 1 next cycle, the TX FIFO emits 0x00, and `prog_stop` stays 1 until reset.
- Reset mid-traffic: assert `rst_in` with both FIFOs half full. The next cycle shows `tx_valid` = 0, `rdy_out` = 1 and counter = 0, and a following read of 0x30000 returns 0x00.
